ro_vn_extractor: RTL and testbench



---
 rtl/ro_vn_extractor.sv | 130 +++++++++++++
 tb/tb_ro_vn_extractor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ro_vn_extractor.sv
// Ring-oscillator sampler: 2-flop synchronizer, fixed-rate strobe, von Neumann
// pair extractor, byte packer and show-ahead byte FIFO with valid/ready read.
module ro_vn_extractor #(
  parameter int unsigned SAMPLE_DIV = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       ro_in,
  input  logic       en,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] drop_cnt
);

  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(SAMPLE_DIV - 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic {FIRST, SECOND} pair_state_t;

  logic              sync1, sync2;
  logic [TW-1:0]     tcnt;
  logic              strobe;
  pair_state_t       state, state_nxt;
  logic              first_bit;
  logic              emit;
  // Only the 7 oldest bits are stored; the 8th goes straight into the FIFO.
  logic [6:0]        shreg;
  logic [2:0]        bcnt;
  logic              push;
  logic [7:0]        byte_in;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     rptr, wptr;
  logic [CW-1:0]     count;
  logic              pop, accept;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)              tcnt <= '0;
    else if (!en)            tcnt <= '0;
    else if (tcnt == TMAX)   tcnt <= '0;
    else                     tcnt <= tcnt + 1'b1;
  end

  assign strobe = en && (tcnt == TMAX);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= FIRST;
      first_bit <= 1'b0;
    end else begin
      state <= state_nxt;
      if (strobe && state == FIRST) first_bit <= sync2;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (!en) begin
      state_nxt = FIRST;
    end else if (strobe) begin
      unique case (state)
        FIRST:  state_nxt = SECOND;
        SECOND: begin
          state_nxt = FIRST;
          emit      = (sync2 != first_bit);
        end
        default: state_nxt = FIRST;
      endcase
    end
  end

  // Emitted bit equals first_bit for both surviving pairs (10 -> 1, 01 -> 0).
  assign byte_in = {shreg, first_bit};
  assign push    = emit && (bcnt == 3'd7);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (!en) begin
      bcnt <= '0;
    end else if (emit) begin
      shreg <= byte_in[6:0];
      bcnt  <= bcnt + 3'd1;
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rptr] : '0;
  assign pop      = rd_valid && rd_ready;
  assign accept   = push && ((count != FULL) || pop);

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= byte_in;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ro_vn_extractor.sv
// Directed bench for ro_vn_extractor with SAMPLE_DIV=4, FIFO_DEPTH=4.
module tb_ro_vn_extractor;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       ro_in;
  logic       en;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ro_vn_extractor #(.SAMPLE_DIV(SD), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .ro_in    (ro_in),
    .en       (en),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Restart sampling so the next strobe lands SD cycles after this point.
  task automatic start_en();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  // Hold ro_in for one sample period; optionally accept a byte in the strobe cycle.
  task automatic sample(input logic v, input logic pop_last);
    ro_in = v;
    repeat (SD - 1) @(negedge clk);
    rd_ready = pop_last;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic pop_last);
    sample(b, 1'b0);
    sample(~b, pop_last);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pop_last);
    for (int i = 7; i >= 0; i--) send_bit(b[i], pop_last && (i == 0));
  endtask

  task automatic drain(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  logic [19:0] pairs;

  initial begin
    rst_b = 1'b0; ro_in = 1'b0; en = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);

    // Constant input: every pair is 11, nothing survives.
    start_en();
    ro_in = 1'b1;
    repeat (400) @(negedge clk);
    check("const_valid", {31'd0, rd_valid}, 32'd0);
    check("const_drop", {24'd0, drop_cnt}, 32'd0);

    // Pairs 10,01,10,10,00,01,01,11,10,01 -> bits 1011_0010 = 0xB2.
    pairs = 20'b10_01_10_10_00_01_01_11_10_01;
    start_en();
    for (int i = 19; i >= 1; i--) sample(pairs[i], 1'b0);
    check("pack_before", {31'd0, rd_valid}, 32'd0);
    sample(pairs[0], 1'b0);
    check("pack_valid", {31'd0, rd_valid}, 32'd1);
    check("pack_data", {24'd0, rd_data}, 32'hB2);
    en = 1'b0;
    drain("pack_pop", 8'hB2);
    check("pack_empty", {31'd0, rd_valid}, 32'd0);

    // Overflow: six bytes into a 4-deep FIFO.
    start_en();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    en = 1'b0;
    check("ovf_valid", {31'd0, rd_valid}, 32'd1);
    check("ovf_drop", {24'd0, drop_cnt}, 32'd2);
    repeat (3) @(negedge clk);
    check("ovf_hold", {24'd0, rd_data}, 32'h01);
    for (int i = 1; i <= 4; i++) drain("ovf_rd", 8'(i));
    check("ovf_empty", {31'd0, rd_valid}, 32'd0);

    // Push while full with a pop in the same cycle: accepted, no drop.
    start_en();
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b0);
    send_byte(8'h15, 1'b1);
    en = 1'b0;
    check("pp_drop", {24'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) drain("pp_rd", 8'h12 + 8'(i));
    check("pp_empty", {31'd0, rd_valid}, 32'd0);

    // Saturation of the drop counter; stored bytes must survive the drops.
    start_en();
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b0);
    for (int i = 1; i <= 300; i++) begin
      send_byte(8'hA5, 1'b0);
      if (i == 252) check("sat_254", {24'd0, drop_cnt}, 32'd254);
      if (i == 253) check("sat_255", {24'd0, drop_cnt}, 32'd255);
    end
    check("sat_end", {24'd0, drop_cnt}, 32'd255);
    en = 1'b0;
    for (int i = 0; i < 4; i++) drain("sat_rd", 8'h21 + 8'(i));
    check("sat_empty", {31'd0, rd_valid}, 32'd0);

    // Enable drop mid-byte discards the partial bits.
    start_en();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    send_byte(8'h55, 1'b0);
    en = 1'b0;
    drain("en_rd", 8'h55);
    check("en_single", {31'd0, rd_valid}, 32'd0);

    // Asynchronous reset between edges with a queued byte and 5 pending bits.
    start_en();
    send_byte(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("ar_pre_valid", {31'd0, rd_valid}, 32'd1);
    #1 rst_b = 1'b0;
    #1;
    check("ar_valid", {31'd0, rd_valid}, 32'd0);
    check("ar_data", {24'd0, rd_data}, 32'd0);
    check("ar_drop", {24'd0, drop_cnt}, 32'd0);
    #1 rst_b = 1'b1;
    @(negedge clk);
    start_en();
    send_byte(8'hC3, 1'b0);
    en = 1'b0;
    drain("ar_rd", 8'hC3);
    check("ar_empty", {31'd0, rd_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
